// File: rtl/mvm_host_sequencer.sv
// Host-side sequencer for the MVM load/start/done protocol: buffers a command's payload, replays
// it as loadMatrix/loadVector bursts, fires start, then forwards the K results that follow done.
module mvm_host_sequencer #(
    parameter int unsigned K       = 8,
    parameter int unsigned B       = 20,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [B-1:0]   cmd_data,
    output logic           loadMatrix,
    output logic           loadVector,
    output logic           start,
    output logic [B-1:0]   data_in,
    input  logic           done,
    input  logic [2*B-1:0] data_out,
    output logic           res_valid,
    output logic [2*B-1:0] res_data,
    output logic           res_last,
    output logic           busy,
    output logic           err
);

    localparam int unsigned NMax   = K * K + K;
    localparam int unsigned CntMax = (TIMEOUT > NMax) ? TIMEOUT : NMax;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam int unsigned PW     = $clog2(NMax);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StGap,
        StHdr,
        StBurst,
        StStart,
        StWait,
        StCollect
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [2:0]      r_mode, w_mode_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]      r_seg, w_seg_nxt;    // bursts completed so far
    logic [PW-1:0]   r_ptr, w_ptr_nxt;    // buffer read pointer, runs across both bursts
    logic            r_err, w_err_nxt;
    logic            r_alive;             // holds cmd_ready low during the reset cycle
    logic [2*B-1:0]  r_res;
    logic [B-1:0]    r_buf [NMax];

    logic            w_cmd_fire;
    logic            w_mode_ok;
    logic            w_buf_we;
    logic            w_two;
    logic            w_is_mat;
    logic            w_gap_end;
    logic [CW-1:0]   w_n;
    logic [CW-1:0]   w_len;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_mode_ok  = (cmd_data >= B'(1)) && (cmd_data <= B'(4));
    assign w_two      = (r_mode == 3'd1) || (r_mode == 3'd2);
    // Mode 1 loads the matrix first, mode 2 second, mode 3 only.
    assign w_is_mat   = (r_mode == 3'd3) || ((r_mode == 3'd1) && (r_seg == 2'd0)) ||
                        ((r_mode == 3'd2) && (r_seg == 2'd1));
    assign w_n        = (r_mode == 3'd3) ? CW'(K * K) :
                        (r_mode == 3'd4) ? CW'(K) : CW'(K * K + K);
    assign w_len      = w_is_mat ? CW'(K * K) : CW'(K);
    assign w_gap_end  = (32'(r_cnt) + 32'd1) >= GAP;

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_mode  <= 3'd0;
            r_cnt   <= '0;
            r_seg   <= 2'd0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_alive <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg   <= w_seg_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err_nxt;
            r_alive <= 1'b1;
            r_res   <= data_out;
        end
    end

    // Payload buffer, written in arrival order during FILL.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_cnt[PW-1:0]] <= cmd_data;
        end
    end

    // Next-state logic and decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_seg;
        w_ptr_nxt   = r_ptr;
        w_err_nxt   = r_err;
        w_buf_we    = 1'b0;

        cmd_ready   = 1'b0;
        loadMatrix  = 1'b0;
        loadVector  = 1'b0;
        start       = 1'b0;
        data_in     = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        res_last    = 1'b0;
        busy        = (r_state != StIdle);
        err         = r_err;

        unique case (r_state)
            StIdle: begin
                cmd_ready = r_alive;
                if (w_cmd_fire) begin
                    if (w_mode_ok) begin
                        w_mode_nxt  = cmd_data[2:0];
                        w_cnt_nxt   = '0;
                        w_state_nxt = StFill;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            StFill: begin
                cmd_ready = r_alive;
                if (w_cmd_fire) begin
                    w_buf_we  = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == w_n - 1'b1) begin
                        w_state_nxt = StGap;
                        w_cnt_nxt   = '0;
                        w_seg_nxt   = 2'd0;
                        w_ptr_nxt   = '0;
                    end
                end
            end
            StGap: begin
                if (w_gap_end) begin
                    w_cnt_nxt = '0;
                    if ((r_seg == 2'd0) || ((r_seg == 2'd1) && w_two)) begin
                        w_state_nxt = StHdr;
                    end else begin
                        w_state_nxt = StStart;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StHdr: begin
                loadMatrix  = w_is_mat;
                loadVector  = !w_is_mat;
                w_state_nxt = StBurst;
            end
            StBurst: begin
                data_in   = r_buf[r_ptr];
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_cnt == w_len - 1'b1) begin
                    w_state_nxt = StGap;
                    w_cnt_nxt   = '0;
                    w_seg_nxt   = r_seg + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StStart: begin
                start       = 1'b1;
                w_state_nxt = StWait;
                w_cnt_nxt   = CW'(1);   // cycles elapsed since start
            end
            StWait: begin
                if (done) begin
                    w_state_nxt = StCollect;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StCollect: begin
                res_valid = 1'b1;
                res_data  = r_res;
                res_last  = (r_cnt == CW'(K - 1));
                if (r_cnt == CW'(K - 1)) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: doc/mvm_host_sequencer.md
Name: mvm_host_sequencer

Overview:
Host-side initiator for the mvm_K_K_B_1 load/start/done protocol.
- Accepts a command stream on a valid/ready port: one mode word, then the payload, in the same word layout as the refData memory images.
- Buffers the full payload, then drives it to the MVM as contiguous bursts with loadMatrix/loadVector/start pulses.
- Captures the K results that follow done and re-emits them on a result port.
- Used wherever an MVM instance is fed by on-chip logic instead of a bench.

Parameters:
K, 8, matrix dimension (K*K matrix, K-element vector)
B, 20, data word width; results are 2*B
GAP, 2, idle cycles inserted between phases (after each burst, before start)
TIMEOUT, 4096, cycles to wait for done before flagging error

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command word valid
cmd_ready  out  1  sequencer accepts cmd_data this cycle
cmd_data  in  B  mode word or payload word
loadMatrix  out  1  one-cycle pulse, matrix burst follows
loadVector  out  1  one-cycle pulse, vector burst follows
start  out  1  one-cycle pulse, begin multiply
data_in  out  B  burst data to MVM (signed)
done  in  1  MVM completion pulse
data_out  in  2*B  MVM result stream (signed)
res_valid  out  1  res_data valid
res_data  out  2*B  captured result
res_last  out  1  marks result K-1
busy  out  1  high in every state except IDLE
err  out  1  sticky error flag

Behaviour:
- Reset (reset==0 at a clk edge): FSM to IDLE and payload count to 0. All outputs go to 0, including cmd_ready and err. cmd_ready rises the first cycle after reset is released. Reset mid-operation aborts immediately with no pulses emitted afterwards.
- Mode word, accepted in IDLE on cmd_valid&&cmd_ready:
  - 1: matrix then vector, N=K*K+K payload words.
  - 2: vector then matrix, N=K*K+K.
  - 3: matrix only, N=K*K.
  - 4: vector only, N=K.
  - Any other value: err<=1, word discarded, stay in IDLE.
- FILL:
  - cmd_ready=1; each handshake writes cmd_data to buffer[cnt] in arrival order.
  - cmd_valid gaps are allowed.
  - After word N-1 is accepted, cmd_ready drops in the same cycle the FSM leaves FILL.
  - cmd_ready=0 in all states other than IDLE/FILL.
- Buffer: (K*K+K) x B register array. Burst order equals arrival order.
- Phase sequence: FILL -> GAP -> HDR1 -> BURST1 -> GAP -> [HDR2 -> BURST2 -> GAP] -> START -> WAIT_DONE -> COLLECT -> IDLE.
  - The bracketed phase exists only for modes 1 and 2.
  - GAP lasts exactly GAP cycles.
- Load header and burst timing:
  - HDR asserts loadMatrix or loadVector (per mode and phase) for exactly one cycle t.
  - Burst drives data_in=buffer word i in cycle t+1+i, contiguous with no holes.
  - Matrix burst is row-major, K*K words; vector burst is K words.
  - data_in=0 outside bursts.
- START: start=1 for one cycle.
- WAIT_DONE:
  - Internal counter counts cycles.
  - done==1 -> COLLECT.
  - Counter reaches TIMEOUT -> err<=1, return to IDLE, no results emitted.
- COLLECT:
  - If done is seen high in cycle d, then in cycles d+1..d+K: res_valid=1 and res_data=data_out registered from that same cycle, i.e. res_valid/res_data appear one cycle after the corresponding data_out sample.
  - res_last=1 with the K-th result.
  - There is no backpressure on the result port.
  - Then return to IDLE; cmd_ready=1 the next cycle.
- done outside WAIT_DONE is ignored, including a done coincident with START.
- err clears only on reset. err does not block further commands.
- Back-to-back commands: a mode word presented while busy is held off by cmd_ready=0.

Test Plan:
- Mode 1, matrix=identity, vector=1..8, behavioural MVM responder -> loadMatrix at t, 64 contiguous data_in words t+1..t+64, GAP=2, loadVector pulse, 8 words, start. After done, res_data=1..8 on 8 consecutive res_valid cycles, res_last on 8.
- Mode 3 (matrix all 2s) then mode 4 (vector all 1s) -> first command emits no loadVector; second emits no loadMatrix. Both emit start; second results all 16.
- Mode 2 with cmd_valid toggling every other cycle during FILL -> vector burst before matrix burst, both bursts still contiguous, data order matches stream order.
- Mode word 7 -> err=1 next cycle, no pulses, cmd_ready stays 1. Following mode 4 command completes normally with err still 1.
- Responder never asserts done, TIMEOUT=64 -> err=1 exactly 64 cycles after start, busy=0, res_valid never asserted.
- reset=0 during BURST1 word 20 -> next cycle all outputs 0. No further data_in/start. New mode 1 command after release runs cleanly from word 0.
